// File: rtl/ca_rule_sequencer_if.sv
// Control/table bus between the sync generator/user pins and ca_rule_sequencer.
//   frame_start  : one-cycle pulse at pixel (0,0)
//   hold         : level, freezes auto-advance
//   step_btn     : asynchronous push button, rising edge requests one advance
//   wr_en/wr_addr/wr_data : runtime rule-table write port
//   rule/rule_color/rule_idx : active rule, its display colour and table index
//   rule_changed : one-cycle pulse after a frame_start that changed the rule
//   seed_req     : level, held for the frame following a rule change
interface ca_rule_sequencer_if;
  logic       frame_start;
  logic       hold;
  logic       step_btn;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rule;
  logic [5:0] rule_color;
  logic [2:0] rule_idx;
  logic       rule_changed;
  logic       seed_req;

  modport master (
    output frame_start, hold, step_btn, wr_en, wr_addr, wr_data,
    input  rule, rule_color, rule_idx, rule_changed, seed_req
  );

  modport slave (
    input  frame_start, hold, step_btn, wr_en, wr_addr, wr_data,
    output rule, rule_color, rule_idx, rule_changed, seed_req
  );
endinterface

// File: rtl/ca_rule_sequencer.sv
// Rule sequencer for the cellular-automaton VGA renderer. Owns the 8-entry
// elementary-CA rule table and selects the active rule; selection only moves
// on frame boundaries so the picture never tears mid-frame.
// Ports:
//   clk   : pixel clock
//   rst_n : synchronous active-low reset
//   bus   : ca_rule_sequencer_if.slave (frame_start, hold, step_btn, table
//           write port in; rule, rule_color, rule_idx, rule_changed, seed_req out)
module ca_rule_sequencer #(
  parameter int unsigned DWELL_FRAMES = 60,
  parameter int unsigned DW_W         = 10,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ca_rule_sequencer_if.slave   bus
);

  function automatic logic [7:0] f_init_rule(input logic [2:0] i);
    case (i)
      3'd0:    f_init_rule = 8'd30;
      3'd1:    f_init_rule = 8'd110;
      3'd2:    f_init_rule = 8'd22;
      3'd3:    f_init_rule = 8'd73;
      3'd4:    f_init_rule = 8'd90;
      3'd5:    f_init_rule = 8'd146;
      3'd6:    f_init_rule = 8'd105;
      default: f_init_rule = 8'd102;
    endcase
  endfunction

  // Colour is rule[6:1]; an all-zero field would be invisible, so substitute.
  function automatic logic [5:0] f_color(input logic [7:0] r);
    f_color = (r[6:1] == 6'd0) ? 6'b010101 : r[6:1];
  endfunction

  logic [7:0]             r_table [8];
  logic [2:0]             r_idx;
  logic [7:0]             r_rule;
  logic [5:0]             r_color;
  logic [DW_W-1:0]        r_dwell;
  logic                   r_step_pending;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_q;
  logic                   r_changed;
  logic                   r_seed;

  logic                   w_step_edge;
  logic                   w_dwell_done;
  logic                   w_advance;
  logic [2:0]             w_next_idx;
  logic [7:0]             w_next_rule;

  always_comb begin
    w_step_edge  = r_sync[SYNC_STAGES-1] & ~r_sync_q;
    // >= rather than == so an out-of-range dwell still forces an advance.
    w_dwell_done = (r_dwell >= DW_W'(DWELL_FRAMES - 1));
    w_advance    = r_step_pending | (~bus.hold & w_dwell_done);
    w_next_idx   = w_advance ? r_idx + 3'd1 : r_idx;
    // Reload sees the table after a same-cycle write, so bypass the write data.
    w_next_rule  = (bus.wr_en && (bus.wr_addr == w_next_idx)) ? bus.wr_data
                                                              : r_table[w_next_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) r_table[i] <= f_init_rule(3'(i));
      r_idx          <= '0;
      r_rule         <= 8'd30;
      r_color        <= 6'b001111;
      r_dwell        <= '0;
      r_step_pending <= 1'b0;
      r_sync         <= '0;
      r_sync_q       <= 1'b0;
      r_changed      <= 1'b0;
      r_seed         <= 1'b0;
    end else begin
      r_sync    <= (r_sync << 1) | SYNC_STAGES'(bus.step_btn);
      r_sync_q  <= r_sync[SYNC_STAGES-1];
      r_changed <= 1'b0;

      if (bus.wr_en) r_table[bus.wr_addr] <= bus.wr_data;

      if (bus.frame_start) begin
        r_idx     <= w_next_idx;
        r_rule    <= w_next_rule;
        r_color   <= f_color(w_next_rule);
        r_changed <= (w_next_rule != r_rule);
        r_seed    <= (w_next_rule != r_rule);
        if (w_advance)      r_dwell <= '0;
        else if (!bus.hold) r_dwell <= r_dwell + DW_W'(1);
        // An edge landing on the boundary cycle is kept for the next frame.
        r_step_pending <= w_step_edge;
      end else begin
        r_step_pending <= r_step_pending | w_step_edge;
      end
    end
  end

  assign bus.rule         = r_rule;
  assign bus.rule_color   = r_color;
  assign bus.rule_idx     = r_idx;
  assign bus.rule_changed = r_changed;
  assign bus.seed_req     = r_seed;

endmodule

// File: tb/tb_ca_rule_sequencer.sv
module tb_ca_rule_sequencer;
  localparam int D = 60;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ca_rule_sequencer_if bus ();

  ca_rule_sequencer #(.DWELL_FRAMES(D), .DW_W(10), .SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int chg_cnt = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  int m_tbl [8];
  int m_idx, m_dwell, m_rule;
  bit m_pend, m_chg, m_seed;
  bit m_hist [0:S];
  const int init_tbl [8] = '{30, 110, 22, 73, 90, 146, 105, 102};

  function automatic int color_of(input int r);
    int c;
    c = (r / 2) % 64;
    return (c == 0) ? 21 : c;
  endfunction

  always @(posedge clk) begin
    bit edge_seen;
    bit adv;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_tbl[i] = init_tbl[i];
      m_idx = 0; m_dwell = 0; m_rule = 30; m_pend = 0; m_chg = 0; m_seed = 0;
      for (int k = 0; k <= S; k++) m_hist[k] = 0;
    end else begin
      // button level as seen S edges ago vs S+1 edges ago
      edge_seen = m_hist[S-1] && !m_hist[S];
      if (bus.wr_en) m_tbl[bus.wr_addr] = bus.wr_data;
      if (bus.frame_start) begin
        adv = m_pend || (!bus.hold && m_dwell >= D - 1);
        if (adv) begin
          m_idx = (m_idx + 1) % 8;
          m_dwell = 0;
        end else if (!bus.hold) begin
          m_dwell = m_dwell + 1;
        end
        m_chg  = (m_tbl[m_idx] != m_rule);
        m_seed = m_chg;
        m_rule = m_tbl[m_idx];
        m_pend = edge_seen;
      end else begin
        m_chg  = 0;
        m_pend = m_pend || edge_seen;
      end
      for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = bus.step_btn;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("rule",         int'(bus.rule),         m_rule);
      check("rule_idx",     int'(bus.rule_idx),     m_idx);
      check("rule_color",   int'(bus.rule_color),   color_of(m_rule));
      check("rule_changed", int'(bus.rule_changed), int'(m_chg));
      check("seed_req",     int'(bus.seed_req),     int'(m_seed));
      if (bus.rule_changed === 1'b1) chg_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic frame();
    @(negedge clk) bus.frame_start = 1'b1;
    @(negedge clk) bus.frame_start = 1'b0;
    cyc(3);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic press(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.step_btn = 1'b1;
      cyc(2);
      @(negedge clk) bus.step_btn = 1'b0;
      cyc(2);
    end
    cyc(4);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  int c0;

  initial begin
    bus.frame_start = 1'b0; bus.hold = 1'b0; bus.step_btn = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    cyc(2);
    chk_en = 1'b1;
    @(negedge clk) rst_n = 1'b1;

    // reset state
    probe();
    check("rst_rule",  bus.rule, 30);
    check("rst_idx",   bus.rule_idx, 0);
    check("rst_color", bus.rule_color, 6'b001111);
    check("rst_seed",  bus.seed_req, 0);

    // auto dwell: 59 frames stay on rule 30, the 60th advances
    c0 = chg_cnt;
    frames(59);
    check("dwell59_idx", bus.rule_idx, 0);
    frame();
    check("dwell60_idx",   bus.rule_idx, 1);
    check("dwell60_rule",  bus.rule, 110);
    check("dwell60_color", bus.rule_color, 6'b110111);
    check("dwell60_pulses", chg_cnt - c0, 1);

    // hold freezes dwell
    do_reset();
    frames(10);
    bus.hold = 1'b1;
    c0 = chg_cnt;
    frames(200);
    check("hold_idx", bus.rule_idx, 0);
    check("hold_pulses", chg_cnt - c0, 0);
    bus.hold = 1'b0;
    frames(49);
    check("release49_idx", bus.rule_idx, 0);
    frame();
    check("release50_idx", bus.rule_idx, 1);

    // three presses in one frame under hold -> a single advance
    bus.hold = 1'b1;
    press(3);
    frame();
    check("step_idx", bus.rule_idx, 2);
    frame();
    check("step_once_idx", bus.rule_idx, 2);
    // dwell was cleared by the step
    bus.hold = 1'b0;
    frames(59);
    check("step_dwell59", bus.rule_idx, 2);
    frame();
    check("step_dwell60", bus.rule_idx, 3);

    // wrap 7 -> 0
    do_reset();
    bus.hold = 1'b1;
    for (int i = 0; i < 7; i++) begin press(1); frame(); end
    check("idx7",  bus.rule_idx, 7);
    check("rule7", bus.rule, 102);
    c0 = chg_cnt;
    press(1);
    frame();
    check("wrap_idx",  bus.rule_idx, 0);
    check("wrap_rule", bus.rule, 30);
    check("wrap_pulse", chg_cnt - c0, 1);

    // mid-frame write to the active index is shadowed until frame_start
    @(negedge clk) begin bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'd150; end
    @(negedge clk) bus.wr_en = 1'b0;
    probe();
    check("shadow_rule", bus.rule, 30);
    c0 = chg_cnt;
    @(negedge clk) bus.frame_start = 1'b1;
    @(negedge clk) bus.frame_start = 1'b0;
    #1;
    check("wr_rule",    bus.rule, 150);
    check("wr_color",   bus.rule_color, 6'b001011);
    check("wr_changed", bus.rule_changed, 1);
    cyc(3);
    check("wr_seed_late", bus.seed_req, 1);
    frame();
    check("wr_seed_clear", bus.seed_req, 0);
    check("wr_pulses", chg_cnt - c0, 1);

    // same value rewrite -> no change reported
    do_reset();
    @(negedge clk) begin bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'd30; end
    @(negedge clk) bus.wr_en = 1'b0;
    c0 = chg_cnt;
    frame();
    check("same_pulses", chg_cnt - c0, 0);

    // write on the next index in the same cycle as frame_start
    press(1);
    @(negedge clk) begin
      bus.frame_start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 8'h81;
    end
    @(negedge clk) begin bus.frame_start = 1'b0; bus.wr_en = 1'b0; end
    #1;
    check("coinc_idx",   bus.rule_idx, 1);
    check("coinc_rule",  bus.rule, 8'h81);
    check("coinc_color", bus.rule_color, 6'b010101);

    // reset mid-frame at idx 5
    for (int i = 0; i < 4; i++) begin press(1); frame(); end
    check("pre_rst_idx", bus.rule_idx, 5);
    cyc(1);
    c0 = chg_cnt;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("mrst_rule", bus.rule, 30);
    check("mrst_idx",  bus.rule_idx, 0);
    check("mrst_chg",  bus.rule_changed, 0);
    check("mrst_seed", bus.seed_req, 0);
    cyc(4);
    check("mrst_pulses", chg_cnt - c0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
